// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer chain: word width,
// layer sizes and the transmitter state encoding.
package fc_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int FC1_OUT    = 84;
    localparam int FC2_OUT    = 10;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WRITE = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } fc_state_t;

endpackage

// File: rtl/fc_act_bank.sv
// Activation register bank: NUM_OUT words written one at a time by index,
// read back all at once as a flat bus (word k at bits k*DATA_WIDTH).
module fc_act_bank
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = fc_pkg::DATA_WIDTH,
    parameter int NUM_OUT    = fc_pkg::FC1_OUT,
    parameter int IDX_W      = $clog2(NUM_OUT + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic [NUM_OUT*DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] words [NUM_OUT];

    // Clear the bank on reset, otherwise store one word at the write index;
    // out-of-range indices are dropped so the array is never overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en && (wr_idx < IDX_W'(NUM_OUT))) begin
            words[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_flat
        assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = words[g];
    end

endmodule

// File: rtl/fc1_to_fc2_tx.sv
// FC1 -> FC2 transmitter: gathers the serial FC1 activations into a bank,
// then hands the full bank to FC2 with a write pulse followed by a start
// pulse, and waits for FC2's end pulse before handing over the next frame.
// The bank may be refilled while FC2 is computing, since FC2 has already
// latched its copy.
module fc1_to_fc2_tx
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH  = fc_pkg::DATA_WIDTH,
    parameter int NUM_OUT     = fc_pkg::FC1_OUT,
    parameter int CNT_W       = $clog2(NUM_OUT + 1),
    parameter int FRAME_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] data_out,
    output logic                          ifm_enable_write_previous,
    output logic                          start_from_previous,
    input  logic                          end_to_previous,
    output logic                          fc2_busy,
    output logic [FRAME_CNT_W-1:0]        frames_sent
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_OUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OUT - 1);

    fc_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             fill_done;

    // Words are only taken while filling (first frame or refill during
    // BUSY) and while the bank still has room.
    assign in_ready  = (cnt < FULL) && ((state == FILL) || (state == BUSY));
    assign accept    = in_valid && in_ready;
    // Bank is complete either already, or with the word accepted this cycle.
    assign fill_done = (cnt == FULL) || (accept && (cnt == LAST));

    fc_act_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_OUT    (NUM_OUT),
        .IDX_W      (CNT_W)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (accept),
        .wr_idx   (cnt),
        .wr_data  (in_data),
        .data_out (data_out)
    );

    // Control FSM: fill counter, frame counter and registered handshake
    // pulses all move together so write and start can never overlap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state                     <= FILL;
            cnt                       <= '0;
            ifm_enable_write_previous <= 1'b0;
            start_from_previous       <= 1'b0;
            fc2_busy                  <= 1'b0;
            frames_sent               <= '0;
        end else begin
            ifm_enable_write_previous <= 1'b0;
            start_from_previous       <= 1'b0;
            if (accept) begin
                cnt <= cnt + 1'b1;
            end
            case (state)
                FILL: begin
                    if (accept && (cnt == LAST)) begin
                        state                     <= WRITE;
                        ifm_enable_write_previous <= 1'b1;
                        fc2_busy                  <= 1'b1;
                    end
                end
                WRITE: begin
                    cnt                 <= '0;
                    state               <= START;
                    start_from_previous <= 1'b1;
                end
                START: begin
                    frames_sent <= frames_sent + 1'b1;
                    state       <= BUSY;
                end
                BUSY: begin
                    if (end_to_previous) begin
                        if (fill_done) begin
                            state                     <= WRITE;
                            ifm_enable_write_previous <= 1'b1;
                        end else begin
                            state    <= FILL;
                            fc2_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc1_to_fc2_tx.sv
// Testbench for fc1_to_fc2_tx: a driver streams activations, a reference
// model groups accepted words into frames and predicts the handshake, and
// a monitor compares the DUT against the predictions every cycle.
module tb_fc1_to_fc2_tx;

    localparam int DW = 32;
    localparam int N  = 84;
    localparam int FW = 16;
    localparam int BW = N * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [BW-1:0] data_out;
    logic          ifm_enable_write_previous;
    logic          start_from_previous;
    logic          end_to_previous;
    logic          fc2_busy;
    logic [FW-1:0] frames_sent;

    always #5 clk = ~clk;

    fc1_to_fc2_tx #(
        .DATA_WIDTH  (DW),
        .NUM_OUT     (N),
        .FRAME_CNT_W (FW)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .in_valid                  (in_valid),
        .in_data                   (in_data),
        .in_ready                  (in_ready),
        .data_out                  (data_out),
        .ifm_enable_write_previous (ifm_enable_write_previous),
        .start_from_previous       (start_from_previous),
        .end_to_previous           (end_to_previous),
        .fc2_busy                  (fc2_busy),
        .frames_sent               (frames_sent)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] pend_frame;
    int            pend_cnt;
    int            start_seen;
    bit            outstanding;
    bit            end_drv;
    bit            prev_exp_write;
    bit            exp_busy;
    int            fc2_cd;
    int            fc2_fixed;
    bit            spur_en;

    // Driver / monitor controls
    bit            drv_en;
    bit            drv_seq;
    bit            drv_cont;
    int            drv_left;
    bit            mon_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic checkFrame(input logic [BW-1:0] f);
        int bad;
        bad = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (data_out[k*DW +: DW] !== f[k*DW +: DW]) bad = k;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL data_out word %0d: got %0h expected %0h",
                     bad, data_out[bad*DW +: DW], f[bad*DW +: DW]);
        end
    endtask

    // Drive one cycle of input; record the word in the model if it is taken.
    task automatic applyStimulus();
        if (!drv_en || drv_left == 0) begin
            in_valid = 1'b0;
        end else begin
            in_valid = drv_cont ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data  = drv_seq ? DW'(pend_cnt + 1) : DW'($urandom);
        end
        #1;
        if (in_valid && in_ready) begin
            pend_frame[pend_cnt*DW +: DW] = in_data;
            pend_cnt++;
            drv_left--;
            if (pend_cnt == N) begin
                exp_q.push_back(pend_frame);
                pend_cnt   = 0;
                pend_frame = '0;
            end
        end
    endtask

    // Predict the handshake for the edge just passed, compare, and play FC2.
    task automatic checkOutput();
        bit end_at_e, free_now, exp_write, exp_start, exp_ready;
        logic [BW-1:0] f;
        end_at_e  = end_drv && outstanding;
        free_now  = !outstanding || end_at_e;
        exp_write = (exp_q.size() > 0) && free_now;
        exp_start = prev_exp_write;
        if (end_at_e) outstanding = 1'b0;
        if (exp_write) exp_busy = 1'b1;
        else if (end_at_e) exp_busy = 1'b0;

        check("write_pulse", 64'(ifm_enable_write_previous), 64'(exp_write));
        check("start_pulse", 64'(start_from_previous), 64'(exp_start));
        check("fc2_busy", 64'(fc2_busy), 64'(exp_busy));
        check("frames_sent", 64'(frames_sent), 64'(FW'(start_seen)));
        if (exp_write) begin
            f = exp_q.pop_front();
            checkFrame(f);
        end
        exp_ready = !exp_write && !exp_start && (exp_q.size() == 0);
        check("in_ready", 64'(in_ready), 64'(exp_ready));

        end_drv = 1'b0;
        if (exp_start) begin
            start_seen++;
            outstanding = 1'b1;
            fc2_cd = (fc2_fixed > 0) ? fc2_fixed : int'($urandom_range(1, 120));
        end else if (outstanding && fc2_cd > 0) begin
            fc2_cd--;
            if (fc2_cd == 0) end_drv = 1'b1;
        end else if (!outstanding && spur_en && !exp_write && $urandom_range(0, 1) == 0) begin
            end_drv = 1'b1;
        end
        end_to_previous = end_drv;
        prev_exp_write  = exp_write;
    endtask

    task automatic checkReset();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_write", 64'(ifm_enable_write_previous), 64'd0);
        check("rst_start", 64'(start_from_previous), 64'd0);
        check("rst_busy", 64'(fc2_busy), 64'd0);
        check("rst_frames", 64'(frames_sent), 64'd0);
        check("rst_data_zero", 64'(data_out == '0), 64'd1);
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #3;
        drv_en = 1'b0; mon_en = 1'b0; drv_left = 0;
        in_valid = 1'b0; end_to_previous = 1'b0; reset = 1'b0;
        exp_q.delete();
        pend_cnt = 0; pend_frame = '0; start_seen = 0; outstanding = 1'b0;
        end_drv = 1'b0; prev_exp_write = 1'b0; exp_busy = 1'b0; fc2_cd = 0;
        repeat (cycles) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkReset();
        #2;
        mon_en = 1'b1;
        drv_en = 1'b1;
    endtask

    task automatic waitFrames(input int target, input int limit, input string name);
        int i;
        i = 0;
        while (start_seen < target && i < limit) begin
            @(posedge clk);
            i++;
        end
        check(name, 64'(start_seen >= target), 64'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) checkOutput();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            applyStimulus();
        end
    end

    initial begin
        int i;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; end_to_previous = 1'b0;
        drv_en = 1'b0; mon_en = 1'b0; drv_seq = 1'b0; drv_cont = 1'b0;
        drv_left = 0; fc2_fixed = 0; spur_en = 1'b0;
        pend_cnt = 0; pend_frame = '0; start_seen = 0;

        // Reset and idle
        doReset(3);
        repeat (5) @(posedge clk);

        // Sequential frames with long FC2 delay (refill and hold in BUSY)
        #3;
        drv_seq = 1'b1; drv_cont = 1'b1; drv_left = 100000; fc2_fixed = 150;
        waitFrames(2, 1000, "wait_hold_frames");
        // End pulse coinciding with the final refill accept
        #3;
        fc2_fixed = 84;
        waitFrames(5, 1500, "wait_coincide_frames");

        // End pulse ignored in FILL with 40 words stored
        doReset(3);
        drv_seq = 1'b1; drv_cont = 1'b1; drv_left = 40; spur_en = 1'b1;
        i = 0;
        while (pend_cnt < 40 && i < 200) begin @(posedge clk); i++; end
        check("wait_fill40", 64'(pend_cnt), 64'd40);
        repeat (30) @(posedge clk);
        #3;
        spur_en = 1'b0; drv_left = 44;
        waitFrames(1, 500, "wait_after_spurious");

        // Reset with 50 words stored in FILL
        doReset(3);
        drv_seq = 1'b1; drv_cont = 1'b1; drv_left = 50;
        i = 0;
        while (pend_cnt < 50 && i < 200) begin @(posedge clk); i++; end
        check("wait_fill50", 64'(pend_cnt), 64'd50);

        // Reset while FC2 is busy
        doReset(3);
        drv_seq = 1'b0; drv_cont = 1'b0; drv_left = 100000; fc2_fixed = 0; spur_en = 1'b1;
        i = 0;
        while (!(start_seen >= 1 && outstanding) && i < 2000) begin @(posedge clk); i++; end
        check("wait_busy", 64'(start_seen >= 1 && outstanding), 64'd1);

        // Randomized frames after the mid-BUSY reset
        doReset(3);
        drv_seq = 1'b0; drv_cont = 1'b0; drv_left = 100000; fc2_fixed = 0; spur_en = 1'b1;
        waitFrames(12, 20000, "wait_random_frames");

        @(posedge clk);
        #3;
        mon_en = 1'b0; drv_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
